// File: rtl/ram_rd_pkg.sv
// Shared types and constants for the RAM stream reader.
package ram_rd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } rd_state_e;

  // Reads in flight plus words buffered may never exceed this.
  localparam int INFLIGHT_MAX = 2;

endpackage

// File: rtl/ram_stream_reader_if.sv
// Valid/ready stream carrying words read out of the RAM.
interface ram_stream_reader_if #(
  parameter int DWIDTH = 32
);
  logic [DWIDTH-1:0] m_data;
  logic              m_valid;
  logic              m_ready;

  modport master (output m_data, output m_valid, input m_ready);
  modport slave  (input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/ram_rd_fifo2.sv
// Two-entry FIFO; the head word stays put while the consumer stalls.
module ram_rd_fifo2 #(
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DWIDTH-1:0] din,
  output logic [DWIDTH-1:0] dout,
  output logic [1:0]        count
);
  logic [1:0][DWIDTH-1:0] mem_q, mem_d;
  logic                   wp_q, wp_d, rp_q, rp_d;
  logic [1:0]             cnt_q, cnt_d;

  always_comb begin
    mem_d = mem_q;
    wp_d  = wp_q;
    rp_d  = rp_q;
    if (push) begin
      mem_d[wp_q] = din;
      wp_d        = ~wp_q;
    end
    if (pop) rp_d = ~rp_q;
    cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q <= '0;
      wp_q  <= 1'b0;
      rp_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      mem_q <= mem_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  assign dout  = mem_q[rp_q];
  assign count = cnt_q;
endmodule

// File: rtl/ram_stream_reader.sv
// Bursts words out of a 1-cycle-latency sync-read RAM onto a valid/ready stream.
// RAM_RD_WRAP_EN: addresses wrap modulo DEPTH; otherwise out-of-range bursts are rejected via err.
module ram_stream_reader
  import ram_rd_pkg::*;
#(
  parameter int AWIDTH = 3,
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [AWIDTH-1:0] base_addr,
  input  logic [AWIDTH:0]   len,
  output logic [AWIDTH-1:0] ram_addr,
  output logic              ram_we,
  input  logic [DWIDTH-1:0] ram_dout,
  ram_stream_reader_if.master m,
  output logic              busy,
`ifndef RAM_RD_WRAP_EN
  output logic              err,
`endif
  output logic              done
);
  rd_state_e         state_q, state_d;
  logic [AWIDTH-1:0] nxt_q, nxt_d, ram_addr_q, ram_addr_d;
  logic [AWIDTH:0]   rem_q, rem_d;
  logic              inflight_q, inflight_d;
  logic [1:0]        fcnt;
  logic              pop, issue, reject;

`ifndef RAM_RD_WRAP_EN
  localparam int DEPTH = 1 << AWIDTH;
  logic [AWIDTH+1:0] end_addr;
  logic              err_q, err_d;
  assign end_addr = {2'b00, base_addr} + {1'b0, len};
  assign reject   = end_addr > (AWIDTH+2)'(DEPTH);
`else
  assign reject   = 1'b0;
`endif

  assign pop = m.m_valid & m.m_ready;
  // Only issue if the word it returns is guaranteed a FIFO slot.
  assign issue = (state_q == ISSUE) &&
                 (({1'b0, fcnt} + {2'b00, inflight_q} - {2'b00, pop}) < 3'(INFLIGHT_MAX));

  always_comb begin
    state_d    = state_q;
    nxt_d      = nxt_q;
    rem_d      = rem_q;
    ram_addr_d = ram_addr_q;
    inflight_d = issue;
`ifndef RAM_RD_WRAP_EN
    err_d      = err_q;
`endif
    case (state_q)
      IDLE: if (start) begin
`ifndef RAM_RD_WRAP_EN
        err_d = reject;
`endif
        if (len == '0 || reject) state_d = FIN;
        else begin
          nxt_d   = base_addr;
          rem_d   = len;
          state_d = ISSUE;
        end
      end
      ISSUE: if (issue) begin
        ram_addr_d = nxt_q;
        nxt_d      = nxt_q + 1'b1;
        rem_d      = rem_q - 1'b1;
        if (rem_q == (AWIDTH+1)'(1)) state_d = DRAIN;
      end
      // Leave on the edge of the final transfer so done follows it directly.
      DRAIN: if (!inflight_q && (fcnt == 2'd0 || (fcnt == 2'd1 && pop))) state_d = FIN;
      FIN: begin
        state_d = IDLE;
`ifndef RAM_RD_WRAP_EN
        err_d   = 1'b0;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      nxt_q      <= '0;
      rem_q      <= '0;
      ram_addr_q <= '0;
      inflight_q <= 1'b0;
`ifndef RAM_RD_WRAP_EN
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      nxt_q      <= nxt_d;
      rem_q      <= rem_d;
      ram_addr_q <= ram_addr_d;
      inflight_q <= inflight_d;
`ifndef RAM_RD_WRAP_EN
      err_q      <= err_d;
`endif
    end
  end

  ram_rd_fifo2 #(.DWIDTH(DWIDTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (inflight_q),
    .pop     (pop),
    .din     (ram_dout),
    .dout    (m.m_data),
    .count   (fcnt)
  );

  assign m.m_valid = (fcnt != 2'd0);
  assign ram_addr  = issue ? nxt_q : ram_addr_q;
  assign ram_we    = 1'b0;
  assign busy      = (state_q == ISSUE) || (state_q == DRAIN);
  assign done      = (state_q == FIN);
`ifndef RAM_RD_WRAP_EN
  assign err       = (state_q == FIN) && err_q;
`endif
endmodule

// File: tb/tb_ram_stream_reader.sv
// Scoreboard bench for ram_stream_reader (AWIDTH=3, DWIDTH=32); honours RAM_RD_WRAP_EN.
module tb_ram_stream_reader;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  base_addr = '0;
  logic [3:0]  len = '0;
  logic [2:0]  ram_addr;
  logic        ram_we;
  logic [31:0] ram_dout;
  logic        busy, done;
`ifndef RAM_RD_WRAP_EN
  logic        err;
`endif

  ram_stream_reader_if #(.DWIDTH(32)) s_if ();

  ram_stream_reader #(.AWIDTH(3), .DWIDTH(32)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_dout  (ram_dout),
    .m         (s_if),
    .busy      (busy),
`ifndef RAM_RD_WRAP_EN
    .err       (err),
`endif
    .done      (done)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [8];
  initial for (int i = 0; i < 8; i++) mem[i] = 32'hC0DE_0000 + 32'(i * 37 + 5);
  always @(posedge clk) ram_dout <= mem[ram_addr];

  int          tests = 0;
  int          fails = 0;
  int          xfer_cnt = 0;
  logic [31:0] exp_q [$];
  bit          prev_stall = 1'b0;
  logic [31:0] prev_data = '0;

  // Monitor: scoreboard pop, stall hold, occupancy bound, RAM never written.
  always @(negedge clk) begin
    logic [31:0] e;
    #2;
    if (reset_n) begin
      tests++;
      if (int'(dut.inflight_q) + int'(dut.fcnt) > 2) begin
        fails++; $display("FAIL occupancy: got %0d, limit 2", int'(dut.inflight_q) + int'(dut.fcnt));
      end
      tests++;
      if (ram_we !== 1'b0) begin fails++; $display("FAIL ram_we: got %b, want 0", ram_we); end
      if (prev_stall) begin
        tests++;
        if (s_if.m_valid !== 1'b1 || s_if.m_data !== prev_data) begin
          fails++; $display("FAIL stall_hold: got v=%b d=%h, want v=1 d=%h", s_if.m_valid, s_if.m_data, prev_data);
        end
      end
      if (s_if.m_valid === 1'b1 && s_if.m_ready === 1'b1) begin
        tests++; xfer_cnt++;
        if (exp_q.size() == 0) begin
          fails++; $display("FAIL extra_word: got %h, want none", s_if.m_data);
        end else begin
          e = exp_q.pop_front();
          if (s_if.m_data !== e) begin fails++; $display("FAIL data: got %h, want %h", s_if.m_data, e); end
        end
      end
      prev_stall = (s_if.m_valid === 1'b1) && (s_if.m_ready !== 1'b1);
      prev_data  = s_if.m_data;
    end else prev_stall = 1'b0;
  end

  function automatic bit burst_ok(input int b, input int n);
`ifdef RAM_RD_WRAP_EN
    return n <= 8;
`else
    return (b + n) <= 8;
`endif
  endfunction

  // Called at a negedge; returns at the first negedge after start was sampled.
  task automatic start_burst(input int b, input int n);
    start = 1'b1; base_addr = 3'(b); len = 4'(n);
    if (burst_ok(b, n)) for (int i = 0; i < n; i++) exp_q.push_back(mem[(b + i) % 8]);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int maxc);
    bit seen = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      if (done === 1'b1) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    tests++;
    if (!seen) begin fails++; $display("FAIL %s_done_timeout: done=0 after %0d cycles, want 1", name, maxc); end
    tests++;
    if (exp_q.size() != 0) begin
      fails++; $display("FAIL %s_missing: %0d words outstanding, want 0", name, exp_q.size());
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    s_if.m_ready = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if (s_if.m_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || ram_addr !== 3'd0) begin
      fails++; $display("FAIL reset_state: got v=%b busy=%b done=%b addr=%0d, want 0/0/0/0",
                        s_if.m_valid, busy, done, ram_addr);
    end
`ifndef RAM_RD_WRAP_EN
    tests++;
    if (err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b, want 0", err); end
`endif
    reset_n = 1'b1;
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || s_if.m_valid !== 1'b0) begin
      fails++; $display("FAIL reset_release: got busy=%b v=%b, want 0/0", busy, s_if.m_valid);
    end
  endtask

  // base=2 len=4, full throughput: cycle-by-cycle addresses, valid window and done.
  task automatic test_basic();
    int exp_addr [6] = '{2, 3, 4, 5, 5, 5};
    bit exp_v    [6] = '{0, 0, 1, 1, 1, 1};
    start_burst(2, 4);
    for (int t = 0; t < 6; t++) begin
      tests++;
      if (ram_addr !== 3'(exp_addr[t]) || s_if.m_valid !== exp_v[t] || busy !== 1'b1 || done !== 1'b0) begin
        fails++; $display("FAIL basic_c%0d: got addr=%0d v=%b busy=%b done=%b, want addr=%0d v=%b busy=1 done=0",
                          t + 1, ram_addr, s_if.m_valid, busy, done, exp_addr[t], exp_v[t]);
      end
      @(negedge clk);
    end
    tests++;
    if (done !== 1'b1 || busy !== 1'b0 || s_if.m_valid !== 1'b0 || exp_q.size() != 0) begin
      fails++; $display("FAIL basic_done: got done=%b busy=%b v=%b left=%0d, want 1/0/0/0",
                        done, busy, s_if.m_valid, exp_q.size());
    end
    @(negedge clk);
    tests++;
    if (done !== 1'b0) begin fails++; $display("FAIL basic_done_pulse: got %b, want 0", done); end
  endtask

  task automatic test_backpressure();
    bit pat [4] = '{1, 0, 0, 1};
    int c = 0;
    start_burst(1, 4);
    while (c < 60 && done !== 1'b1) begin
      s_if.m_ready = pat[c % 4];
      @(negedge clk);
      c++;
    end
    s_if.m_ready = 1'b1;
    wait_done("backpressure", 2);
  endtask

  // Previous burst last issued address 4; len=0 must leave it alone.
  task automatic test_len_zero();
    start_burst(5, 0);
    tests++;
    if (done !== 1'b1 || busy !== 1'b0 || s_if.m_valid !== 1'b0 || ram_addr !== 3'd4) begin
      fails++; $display("FAIL len0_c1: got done=%b busy=%b v=%b addr=%0d, want 1/0/0/4", done, busy, s_if.m_valid, ram_addr);
    end
`ifndef RAM_RD_WRAP_EN
    tests++;
    if (err !== 1'b0) begin fails++; $display("FAIL len0_err: got %b, want 0", err); end
`endif
    @(negedge clk);
    tests++;
    if (done !== 1'b0 || s_if.m_valid !== 1'b0 || ram_addr !== 3'd4) begin
      fails++; $display("FAIL len0_c2: got done=%b v=%b addr=%0d, want 0/0/4", done, s_if.m_valid, ram_addr);
    end
  endtask

  task automatic test_wrap();
`ifdef RAM_RD_WRAP_EN
    int exp_addr [4] = '{6, 7, 0, 1};
    start_burst(6, 4);
    for (int t = 0; t < 4; t++) begin
      tests++;
      if (ram_addr !== 3'(exp_addr[t])) begin
        fails++; $display("FAIL wrap_addr%0d: got %0d, want %0d", t, ram_addr, exp_addr[t]);
      end
      @(negedge clk);
    end
    wait_done("wrap", 10);
`else
    start_burst(6, 4);
    tests++;
    if (err !== 1'b1 || done !== 1'b1 || busy !== 1'b0 || s_if.m_valid !== 1'b0 || ram_addr !== 3'd4) begin
      fails++; $display("FAIL reject: got err=%b done=%b busy=%b v=%b addr=%0d, want 1/1/0/0/4",
                        err, done, busy, s_if.m_valid, ram_addr);
    end
    @(negedge clk);
    tests++;
    if (err !== 1'b0 || done !== 1'b0 || s_if.m_valid !== 1'b0) begin
      fails++; $display("FAIL reject_pulse: got err=%b done=%b v=%b, want 0/0/0", err, done, s_if.m_valid);
    end
`endif
    start_burst(4, 4);
    wait_done("edge_fit", 12);
  endtask

  task automatic test_reset_mid();
    int x0 = xfer_cnt;
    int c = 0;
    start_burst(3, 5);
    while (c < 30 && xfer_cnt - x0 < 2) begin @(negedge clk); #3; c++; end
    tests++;
    if (xfer_cnt - x0 < 2) begin fails++; $display("FAIL rstmid_timeout: got %0d words, want 2", xfer_cnt - x0); end
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    tests++;
    if (s_if.m_valid !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL rstmid_async: got v=%b busy=%b, want 0/0", s_if.m_valid, busy);
    end
    exp_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || s_if.m_valid !== 1'b0 || done !== 1'b0) begin
      fails++; $display("FAIL rstmid_idle: got busy=%b v=%b done=%b, want 0/0/0", busy, s_if.m_valid, done);
    end
    start_burst(0, 1);
    wait_done("rstmid_restart", 10);
  endtask

  task automatic test_start_busy();
    start_burst(1, 3);
    tests++;
    if (ram_addr !== 3'd1) begin fails++; $display("FAIL busy_addr1: got %0d, want 1", ram_addr); end
    start = 1'b1; base_addr = 3'd7; len = 4'd1;
    @(negedge clk);
    start = 1'b0;
    tests++;
    if (ram_addr !== 3'd2) begin fails++; $display("FAIL busy_addr2: got %0d, want 2", ram_addr); end
    @(negedge clk);
    tests++;
    if (ram_addr !== 3'd3) begin fails++; $display("FAIL busy_addr3: got %0d, want 3", ram_addr); end
    wait_done("start_busy", 10);
    tests++;
    if (ram_addr !== 3'd3 || busy !== 1'b0) begin
      fails++; $display("FAIL busy_after: got addr=%0d busy=%b, want 3/0", ram_addr, busy);
    end
  endtask

  initial begin
    s_if.m_ready = 1'b1;
    test_reset();
    test_basic();
    test_backpressure();
    test_len_zero();
    test_wrap();
    test_reset_mid();
    test_start_busy();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation still running at 100000, want finished");
    $fatal(1);
  end
endmodule
